id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage_pkg.sv | 45 ++++
 rtl/id_regfile.sv | 52 +++++
 rtl/id_stage.sv | 170 +++++++++++++++++
 tb/tb_id_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : id_stage_pkg
// Brief   : Opcode constants, field positions and destination selection.
// Revision: 1.0
// ============================================================================
package id_stage_pkg;

   localparam logic [5:0] OP_RTYPE    = 6'h00;
   localparam logic [5:0] OP_JAL      = 6'h03;
   localparam logic [5:0] OP_ITYPE_LO = 6'h08;
   localparam logic [5:0] OP_ITYPE_HI = 6'h0F;
   localparam logic [5:0] OP_LOAD_LO  = 6'h20;
   localparam logic [5:0] OP_LOAD_HI  = 6'h25;

   localparam int OPC_LSB  = 26;
   localparam int RS_LSB   = 21;
   localparam int RT_LSB   = 16;
   localparam int RD_LSB   = 11;
   localparam int IMM_W    = 16;
   localparam int TGT_W    = 26;
   localparam int FUNCT_W  = 6;

   typedef enum logic [1:0] {
      DEST_NONE = 2'd0,
      DEST_RD   = 2'd1,
      DEST_RT   = 2'd2,
      DEST_LINK = 2'd3
   } dest_sel_e;

   function automatic dest_sel_e dest_sel(input logic [5:0] opcode);
      dest_sel_e sel;
      sel = DEST_NONE;
      if (opcode == OP_RTYPE)
         sel = DEST_RD;
      else if ((opcode >= OP_ITYPE_LO && opcode <= OP_ITYPE_HI) ||
               (opcode >= OP_LOAD_LO  && opcode <= OP_LOAD_HI))
         sel = DEST_RT;
      else if (opcode == OP_JAL)
         sel = DEST_LINK;
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_regfile.sv
`default_nettype none
// ============================================================================
// Module  : id_regfile
// Brief   : 2-read / 1-write register file, r0 hardwired to zero, optional bypass.
// Revision: 1.0
// ============================================================================
module id_regfile #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [AW-1:0]   i_raddr_a,
   input  logic [AW-1:0]   i_raddr_b,
   output logic [XLEN-1:0] o_rdata_a,
   output logic [XLEN-1:0] o_rdata_b
);

   logic [XLEN-1:0] r_regs [NREGS];
   logic            w_fwd_a;
   logic            w_fwd_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            r_regs[i] <= '0;
      end else if (i_we && (i_waddr != '0)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   generate
      if (BYPASS != 0) begin : g_bypass
         assign w_fwd_a = i_we && (i_waddr == i_raddr_a);
         assign w_fwd_b = i_we && (i_waddr == i_raddr_b);
      end else begin : g_no_bypass
         assign w_fwd_a = 1'b0;
         assign w_fwd_b = 1'b0;
      end
   endgenerate

   // r0 check comes first so a write-back to r0 is never forwarded
   assign o_rdata_a = (i_raddr_a == '0) ? '0 : (w_fwd_a ? i_wdata : r_regs[i_raddr_a]);
   assign o_rdata_b = (i_raddr_b == '0) ? '0 : (w_fwd_b ? i_wdata : r_regs[i_raddr_b]);

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_stage
// Brief   : Decode stage: operand read, scoreboard interlock, registered output.
// Revision: 1.0
// ============================================================================
module id_stage
   import id_stage_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [5:0]      out_opcode,
   output logic [5:0]      out_funct,
   output logic [XLEN-1:0] out_rs_data,
   output logic [XLEN-1:0] out_rt_data,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_jump_dest,
   output logic [XLEN-1:0] out_branch_dest,
   output logic            out_dest_en,
   output logic [AW-1:0]   out_dest
);

   localparam logic c_BYPASS_EN = (BYPASS != 0);

   logic [5:0]      w_opcode;
   logic [AW-1:0]   w_rs;
   logic [AW-1:0]   w_rt;
   logic [XLEN-1:0] w_rs_data;
   logic [XLEN-1:0] w_rt_data;
   logic [XLEN-1:0] w_imm;
   logic [XLEN-1:0] w_jump_dest;
   logic [XLEN-1:0] w_branch_dest;
   logic [AW-1:0]   w_dest;
   logic            w_dest_en;
   logic            w_rs_fwd;
   logic            w_rt_fwd;
   logic            w_hazard;
   logic            w_accept;
   logic [NREGS-1:0] w_busy_nxt;

   logic [NREGS-1:0] r_busy;
   logic            r_out_valid;
   logic [5:0]      r_opcode;
   logic [5:0]      r_funct;
   logic [XLEN-1:0] r_rs_data;
   logic [XLEN-1:0] r_rt_data;
   logic [XLEN-1:0] r_imm;
   logic [XLEN-1:0] r_jump_dest;
   logic [XLEN-1:0] r_branch_dest;
   logic            r_dest_en;
   logic [AW-1:0]   r_dest;

   assign w_opcode      = in_instr[OPC_LSB +: 6];
   assign w_rs          = in_instr[RS_LSB +: AW];
   assign w_rt          = in_instr[RT_LSB +: AW];
   assign w_imm         = {{(XLEN-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
   assign w_jump_dest   = {in_pc[XLEN-1:28], in_instr[TGT_W-1:0], 2'b00};
   assign w_branch_dest = in_pc + XLEN'(4) + (w_imm << 2);

   always_comb begin
      w_dest = '0;
      case (dest_sel(w_opcode))
         DEST_RD:   w_dest = in_instr[RD_LSB +: AW];
         DEST_RT:   w_dest = in_instr[RT_LSB +: AW];
         DEST_LINK: w_dest = AW'(NREGS - 1);
         default:   w_dest = '0;
      endcase
      w_dest_en = (w_dest != '0);
   end

   id_regfile #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .BYPASS (BYPASS)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_we      (wb_en),
      .i_waddr   (wb_addr),
      .i_wdata   (wb_data),
      .i_raddr_a (w_rs),
      .i_raddr_b (w_rt),
      .o_rdata_a (w_rs_data),
      .o_rdata_b (w_rt_data)
   );

   // A busy source is released early when its write-back is being forwarded
   assign w_rs_fwd = c_BYPASS_EN && wb_en && (wb_addr == w_rs);
   assign w_rt_fwd = c_BYPASS_EN && wb_en && (wb_addr == w_rt);
   assign w_hazard = (r_busy[w_rs] && !w_rs_fwd) || (r_busy[w_rt] && !w_rt_fwd);

   assign in_ready = rst_n && !w_hazard && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready && !flush;

   // Set after clear so an issue to the register being written back stays busy
   always_comb begin
      w_busy_nxt = r_busy;
      if (wb_en)
         w_busy_nxt[wb_addr] = 1'b0;
      if (w_accept && w_dest_en)
         w_busy_nxt[w_dest] = 1'b1;
      if (flush)
         w_busy_nxt = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid   <= 1'b0;
         r_opcode      <= '0;
         r_funct       <= '0;
         r_rs_data     <= '0;
         r_rt_data     <= '0;
         r_imm         <= '0;
         r_jump_dest   <= '0;
         r_branch_dest <= '0;
         r_dest_en     <= 1'b0;
         r_dest        <= '0;
      end else if (flush) begin
         r_out_valid   <= 1'b0;
      end else if (w_accept) begin
         r_out_valid   <= 1'b1;
         r_opcode      <= w_opcode;
         r_funct       <= in_instr[FUNCT_W-1:0];
         r_rs_data     <= w_rs_data;
         r_rt_data     <= w_rt_data;
         r_imm         <= w_imm;
         r_jump_dest   <= w_jump_dest;
         r_branch_dest <= w_branch_dest;
         r_dest_en     <= w_dest_en;
         r_dest        <= w_dest;
      end else if (out_ready) begin
         r_out_valid   <= 1'b0;
      end
   end

   assign out_valid       = r_out_valid;
   assign out_opcode      = r_opcode;
   assign out_funct       = r_funct;
   assign out_rs_data     = r_rs_data;
   assign out_rt_data     = r_rt_data;
   assign out_imm         = r_imm;
   assign out_jump_dest   = r_jump_dest;
   assign out_branch_dest = r_branch_dest;
   assign out_dest_en     = r_dest_en;
   assign out_dest        = r_dest;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_stage
// Brief   : Directed and randomized self-checking bench for id_stage.
// Revision: 1.0
// ============================================================================
module tb_id_stage;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_opcode;
   logic [5:0]  out_funct;
   logic [31:0] out_rs_data;
   logic [31:0] out_rt_data;
   logic [31:0] out_imm;
   logic [31:0] out_jump_dest;
   logic [31:0] out_branch_dest;
   logic        out_dest_en;
   logic [4:0]  out_dest;

   id_stage #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_instr        (in_instr),
      .in_pc           (in_pc),
      .wb_en           (wb_en),
      .wb_addr         (wb_addr),
      .wb_data         (wb_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_opcode      (out_opcode),
      .out_funct       (out_funct),
      .out_rs_data     (out_rs_data),
      .out_rt_data     (out_rt_data),
      .out_imm         (out_imm),
      .out_jump_dest   (out_jump_dest),
      .out_branch_dest (out_branch_dest),
      .out_dest_en     (out_dest_en),
      .out_dest        (out_dest)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [5:0]  opc;
      logic [5:0]  funct;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [31:0] jd;
      logic [31:0] bd;
      logic        den;
      logic [4:0]  dest;
   } pkt_t;

   // Reference model: architectural registers, busy set, held output
   logic [31:0] m_regs [NREGS];
   logic        m_busy [NREGS];
   logic        m_ov;
   pkt_t        m_pkt;
   logic        exp_ready;
   logic        obs_ready;

   task automatic m_reset();
      for (int i = 0; i < NREGS; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      m_ov  = 1'b0;
      m_pkt = '0;
   endtask

   function automatic pkt_t mk_pkt(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] rsv, input logic [31:0] rtv);
      pkt_t p;
      logic [5:0] op;
      op      = ins[31:26];
      p.opc   = op;
      p.funct = ins[5:0];
      p.rs    = rsv;
      p.rt    = rtv;
      p.imm   = {{16{ins[15]}}, ins[15:0]};
      p.jd    = {pc[31:28], ins[25:0], 2'b00};
      p.bd    = pc + 32'd4 + 32'(p.imm * 4);
      if (op == 6'd0)
         p.dest = ins[15:11];
      else if ((op >= 6'd8 && op <= 6'd15) || (op >= 6'd32 && op <= 6'd37))
         p.dest = ins[20:16];
      else if (op == 6'd3)
         p.dest = 5'd31;
      else
         p.dest = 5'd0;
      p.den = (p.dest != 5'd0);
      return p;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (wb_en && wb_addr == r) return wb_data;
      return m_regs[r];
   endfunction

   function automatic pkt_t dut_pkt();
      pkt_t p;
      p.opc   = out_opcode;
      p.funct = out_funct;
      p.rs    = out_rs_data;
      p.rt    = out_rt_data;
      p.imm   = out_imm;
      p.jd    = out_jump_dest;
      p.bd    = out_branch_dest;
      p.den   = out_dest_en;
      p.dest  = out_dest_en ? out_dest : 5'd0;
      return p;
   endfunction

   // Advance one clock, updating the model from the inputs driven this cycle
   task automatic tick();
      logic [4:0] rs;
      logic [4:0] rt;
      logic       haz;
      logic       acc;
      pkt_t       np;
      #1;
      obs_ready = in_ready;
      rs  = in_instr[25:21];
      rt  = in_instr[20:16];
      haz = (m_busy[rs] && !(wb_en && wb_addr == rs)) ||
            (m_busy[rt] && !(wb_en && wb_addr == rt));
      exp_ready = !haz && (!m_ov || out_ready);
      acc = in_valid && exp_ready && !flush;
      np  = mk_pkt(in_instr, in_pc, m_read(rs), m_read(rt));
      if (flush)         m_ov = 1'b0;
      else if (acc)      begin m_ov = 1'b1; m_pkt = np; end
      else if (out_ready) m_ov = 1'b0;
      if (flush) begin
         for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
      end else begin
         if (wb_en) m_busy[wb_addr] = 1'b0;
         if (acc && np.den) m_busy[np.dest] = 1'b1;
      end
      if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
   endtask

   task automatic retire(input logic [4:0] r);
      idle(); wb_en = 1'b1; wb_addr = r; wb_data = 32'h0BAD_0000 | 32'(r);
      tick();
   endtask

   task automatic test_reset();
      idle(); rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'h00A53020;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if ({out_rs_data, out_rt_data, out_imm, out_jump_dest, out_branch_dest, out_opcode, out_funct, out_dest, out_dest_en} !== '0) begin
         errors++; $display("FAIL reset_outputs: got rs=%h rt=%h imm=%h dest=%h expected all zero", out_rs_data, out_rt_data, out_imm, out_dest);
      end
      @(negedge clk);
      rst_n = 1'b1; idle(); m_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_add();
      idle(); wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234; tick();
      idle(); in_valid = 1'b1; in_instr = 32'h00A53020; in_pc = 32'h1000; tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", out_valid); end
      checks++; if (out_rs_data !== 32'h1234) begin errors++; $display("FAIL add_rs: got %h expected 00001234", out_rs_data); end
      checks++; if (out_rt_data !== 32'h1234) begin errors++; $display("FAIL add_rt: got %h expected 00001234", out_rt_data); end
      checks++; if ({out_dest_en, out_dest} !== {1'b1, 5'd6}) begin errors++; $display("FAIL add_dest: got en=%b dest=%0d expected en=1 dest=6", out_dest_en, out_dest); end
      checks++; if ({out_opcode, out_funct} !== {6'h00, 6'h20}) begin errors++; $display("FAIL add_opfn: got %h/%h expected 00/20", out_opcode, out_funct); end
      retire(5'd6);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drop: got %b expected 0", out_valid); end
   endtask

   task automatic test_load_use();
      idle(); in_valid = 1'b1; in_instr = 32'h8C080000; tick();
      checks++; if ({out_dest_en, out_dest} !== {1'b1, 5'd8}) begin errors++; $display("FAIL lw_dest: got en=%b dest=%0d expected en=1 dest=8", out_dest_en, out_dest); end
      idle(); in_valid = 1'b1; in_instr = 32'h01084820;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lw_stall: got %b expected 0", in_ready); end
         tick();
      end
      wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'hCAFEF00D;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lw_bypass_ready: got %b expected 1", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lw_use_valid: got %b expected 1", out_valid); end
      checks++; if ({out_rs_data, out_rt_data} !== {32'hCAFEF00D, 32'hCAFEF00D}) begin errors++; $display("FAIL lw_use_ops: got %h %h expected cafef00d", out_rs_data, out_rt_data); end
      checks++; if (out_dest !== 5'd9) begin errors++; $display("FAIL lw_use_dest: got %0d expected 9", out_dest); end
      retire(5'd9);
   endtask

   task automatic test_backpressure();
      idle(); out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h200A0055; tick();
      checks++; if ({out_valid, out_imm, out_dest} !== {1'b1, 32'h55, 5'd10}) begin errors++; $display("FAIL bp_first: got v=%b imm=%h dest=%0d expected v=1 imm=55 dest=10", out_valid, out_imm, out_dest); end
      in_instr = 32'h200B0066;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", in_ready); end
         tick();
         checks++; if ({out_valid, out_imm, out_dest} !== {1'b1, 32'h55, 5'd10}) begin errors++; $display("FAIL bp_hold: got v=%b imm=%h dest=%0d expected v=1 imm=55 dest=10", out_valid, out_imm, out_dest); end
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
      tick();
      checks++; if ({out_valid, out_imm, out_dest} !== {1'b1, 32'h66, 5'd11}) begin errors++; $display("FAIL bp_second: got v=%b imm=%h dest=%0d expected v=1 imm=66 dest=11", out_valid, out_imm, out_dest); end
      in_valid = 1'b0; tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", out_valid); end
      retire(5'd10);
      retire(5'd11);
   endtask

   task automatic test_jump_branch();
      idle(); in_valid = 1'b1; in_instr = 32'h08000100; in_pc = 32'h40000000; tick();
      checks++; if (out_jump_dest !== 32'h40000400) begin errors++; $display("FAIL jump_dest: got %h expected 40000400", out_jump_dest); end
      checks++; if (out_dest_en !== 1'b0) begin errors++; $display("FAIL jump_dest_en: got %b expected 0", out_dest_en); end
      in_instr = 32'h1000FFFF; in_pc = 32'h100; tick();
      checks++; if (out_branch_dest !== 32'h100) begin errors++; $display("FAIL branch_dest: got %h expected 00000100", out_branch_dest); end
      checks++; if (out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL branch_imm: got %h expected ffffffff", out_imm); end
      idle(); tick();
   endtask

   task automatic test_r0_flush();
      idle(); wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF; tick();
      in_valid = 1'b1; in_instr = 32'h00006020; tick();
      checks++; if ({out_rs_data, out_rt_data} !== 64'd0) begin errors++; $display("FAIL r0_read: got %h %h expected 0", out_rs_data, out_rt_data); end
      idle(); out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h8C080000; tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b expected 1", out_valid); end
      in_instr = 32'h200D0077; flush = 1'b1; tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
      flush = 1'b0; out_ready = 1'b1; in_instr = 32'h01084820;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_r8_free: got %b expected 1", in_ready); end
      tick();
      checks++; if ({out_valid, out_dest} !== {1'b1, 5'd9}) begin errors++; $display("FAIL flush_next: got v=%b dest=%0d expected v=1 dest=9", out_valid, out_dest); end
      retire(5'd9);
   endtask

   task automatic test_reset_mid();
      idle(); out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00A53020; tick();
      checks++; if ({out_valid, out_rs_data} !== {1'b1, 32'h1234}) begin errors++; $display("FAIL rmid_pre: got v=%b rs=%h expected v=1 rs=00001234", out_valid, out_rs_data); end
      rst_n = 1'b0;
      #1;
      checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL rmid_async: got v=%b rdy=%b expected 0 0", out_valid, in_ready); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1; m_reset(); out_ready = 1'b1;
      tick();
      checks++; if ({out_valid, out_rs_data, out_dest} !== {1'b1, 32'h0, 5'd6}) begin errors++; $display("FAIL rmid_first: got v=%b rs=%h dest=%0d expected v=1 rs=0 dest=6", out_valid, out_rs_data, out_dest); end
      retire(5'd6);
   endtask

   task automatic test_random();
      int   bl[$];
      logic [5:0]  op;
      logic [15:0] low;
      pkt_t obs;
      for (int c = 0; c < 800; c++) begin
         idle();
         case ($urandom_range(0, 7))
            0, 1:    op = 6'h00;
            2:       op = 6'h08 + 6'($urandom_range(0, 7));
            3:       op = 6'h20 + 6'($urandom_range(0, 5));
            4:       op = 6'h03;
            5:       op = 6'h02;
            6:       op = 6'h04;
            default: op = 6'($urandom_range(0, 63));
         endcase
         low = 16'($urandom_range(0, 65535));
         if (op == 6'h00) low[15:11] = 5'($urandom_range(0, 7));
         in_instr  = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), low};
         in_pc     = $urandom;
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 9) < 5) begin
            bl.delete();
            for (int r = 1; r < NREGS; r++) if (m_busy[r]) bl.push_back(r);
            wb_en   = 1'b1;
            wb_data = $urandom;
            if (bl.size() != 0 && $urandom_range(0, 9) < 8)
               wb_addr = 5'(bl[$urandom_range(0, bl.size() - 1)]);
            else
               wb_addr = 5'($urandom_range(0, 7));
         end
         tick();
         checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cycle %0d: got %b expected %b", c, obs_ready, exp_ready); end
         checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rand_valid cycle %0d: got %b expected %b", c, out_valid, m_ov); end
         if (m_ov) begin
            obs = dut_pkt();
            checks++; if (obs !== m_pkt) begin errors++; $display("FAIL rand_pkt cycle %0d: got %h expected %h", c, obs, m_pkt); end
         end
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_add();
      test_load_use();
      test_backpressure();
      test_jump_branch();
      test_r0_flush();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
